// File: rtl/rv_mem_arb_pkg.sv
// Shared types and default constants for the unified instruction/data memory arbiter.
package rv_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    localparam int unsigned MAX_D_BURST_DEF = 4;
    localparam int unsigned TIMEOUT_DEF     = 255;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Core-side fetch/data ports and memory-side request/ack bus of the arbiter.
interface imem_dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;

    logic          d_read;
    logic          d_write;
    logic          d_mode;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;

    logic          stall_n;

    logic          mem_req;
    logic          mem_we;
    logic          mem_mode;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          bus_err;

    // The arbiter side.
    modport slave (
        input  if_req, if_addr, d_read, d_write, d_mode, d_addr, d_wdata,
        input  mem_rdata, mem_ack,
        output if_rdata, if_valid, d_rdata, d_valid, stall_n,
        output mem_req, mem_we, mem_mode, mem_addr, mem_wdata, bus_err
    );

    // The core and memory side.
    modport master (
        output if_req, if_addr, d_read, d_write, d_mode, d_addr, d_wdata,
        output mem_rdata, mem_ack,
        input  if_rdata, if_valid, d_rdata, d_valid, stall_n,
        input  mem_req, mem_we, mem_mode, mem_addr, mem_wdata, bus_err
    );

endinterface

// File: rtl/arb_timeout_ctr.sv
// Saturating up-counter with synchronous clear; done flags the terminal count.
module arb_timeout_ctr #(
    parameter int unsigned MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done
);

    localparam int unsigned    W     = $clog2(MAX + 1);
    localparam logic [W-1:0]   MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == MAX_V);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates IF and MEM stage requests onto one single-port memory with a req/ack handshake,
// a data burst limit against fetch starvation, and a timeout abort.
module imem_dmem_arbiter
    import rv_mem_arb_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned MAX_D_BURST = MAX_D_BURST_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input logic               clk,
    input logic               rst,
    imem_dmem_arbiter_if.slave bus
);

    localparam int unsigned  BW        = $clog2(MAX_D_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);

    arb_state_t    state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_mode_q, mem_mode_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic     d_req;
    logic     busy;
    logic     to_done;
    logic     complete;
    logic     grant;
    arb_src_t grant_src;
    logic     if_valid;
    logic     d_valid;

    assign d_req    = bus.d_read | bus.d_write;
    assign busy     = (state_q != IDLE);
    // A timeout ends the access just like an ack; an ack in the same cycle still counts as normal.
    assign complete = busy & (bus.mem_ack | to_done);

    arb_timeout_ctr #(
        .MAX(TIMEOUT)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (~busy | complete),
        .inc (busy & ~bus.mem_ack),
        .done(to_done)
    );

    // Data wins unless a fetch is waiting and data has already had its burst.
    always_comb begin
        grant     = 1'b0;
        grant_src = SRC_I;
        if (d_req && (!bus.if_req || (burst_q < BURST_MAX))) begin
            grant     = 1'b1;
            grant_src = SRC_D;
        end else if (bus.if_req) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_mode_d  = mem_mode_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    mem_req_d = 1'b1;
                    if (grant_src == SRC_D) begin
                        state_d     = BUSY_D;
                        mem_addr_d  = bus.d_addr;
                        mem_we_d    = bus.d_write;
                        mem_wdata_d = bus.d_wdata;
                        mem_mode_d  = bus.d_mode;
                        if (bus.if_req && (burst_q != BURST_MAX)) begin
                            burst_d = burst_q + BW'(1);
                        end
                    end else begin
                        state_d    = BUSY_I;
                        mem_addr_d = bus.if_addr;
                        mem_we_d   = 1'b0;
                        burst_d    = '0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (complete) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        if (!bus.if_req) begin
            burst_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            burst_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_mode_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_mode_q  <= mem_mode_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_valid = (state_q == BUSY_I) & complete;
    assign d_valid  = (state_q == BUSY_D) & complete;

    assign bus.if_valid  = if_valid;
    assign bus.d_valid   = d_valid;
    // On a timeout abort there is no ack, so the requester sees zero data.
    assign bus.if_rdata  = bus.mem_ack ? bus.mem_rdata : '0;
    assign bus.d_rdata   = bus.mem_ack ? bus.mem_rdata : '0;
    assign bus.stall_n   = ~((bus.if_req & ~if_valid) | (d_req & ~d_valid));
    assign bus.bus_err   = busy & to_done & ~bus.mem_ack;

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_mode  = mem_mode_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: stimulus queues expected grants and completions,
// a monitor pops and compares them as the DUT presents them.
module tb_imem_dmem_arbiter;

    localparam int unsigned TO = 8;

    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        mode;
    } gnt_t;

    typedef struct packed {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    gnt_t  gnt_q[$];
    resp_t resp_q[$];

    int ack_lat;
    bit ack_en;
    int busy_cyc;

    imem_dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    imem_dmem_arbiter #(
        .AW(32),
        .DW(32),
        .MAX_D_BURST(4),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] b(input logic v);
        return {31'd0, v};
    endfunction

    // Memory contents as seen by the bench: 0x100 holds 0x00A00093.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return 32'h00A00093 ^ ((a ^ 32'h0000_0100) << 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_gnt_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic m);
        gnt_q.push_back('{is_d: 1'b1, we: we, addr: a, wdata: wd, mode: m});
    endtask

    task automatic push_gnt_i(input logic [31:0] a);
        gnt_q.push_back('{is_d: 1'b0, we: 1'b0, addr: a, wdata: 32'd0, mode: 1'b0});
    endtask

    task automatic push_resp(input logic is_d, input logic [31:0] rd, input logic err);
        resp_q.push_back('{is_d: is_d, rdata: rd, err: err});
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while ((gnt_q.size() != 0 || resp_q.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(gnt_q.size() + resp_q.size()), 32'd0);
    endtask

    // Memory responder: acks in the ack_lat-th cycle of each request.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        busy_cyc      = 0;
        forever begin
            next_cyc();
            if (bus.mem_req) busy_cyc++;
            else busy_cyc = 0;
            if (ack_en && bus.mem_req && busy_cyc == ack_lat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_fn(bus.mem_addr);
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    // Monitor: grants on each mem_req rising edge, completions on each valid.
    initial begin
        logic  prev_req;
        gnt_t  g;
        resp_t r;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (bus.mem_req && !prev_req) begin
                    if (gnt_q.size() == 0) begin
                        check("unexpected_grant", b(bus.mem_req), 32'd0);
                    end else begin
                        g = gnt_q.pop_front();
                        check("gnt_addr", bus.mem_addr, g.addr);
                        check("gnt_we", b(bus.mem_we), b(g.we));
                        if (g.is_d) begin
                            check("gnt_wdata", bus.mem_wdata, g.wdata);
                            check("gnt_mode", b(bus.mem_mode), b(g.mode));
                        end
                    end
                end
                prev_req = bus.mem_req;
                if (bus.if_valid || bus.d_valid) begin
                    if (resp_q.size() == 0) begin
                        check("unexpected_valid", {30'd0, bus.if_valid, bus.d_valid}, 32'd0);
                    end else begin
                        r = resp_q.pop_front();
                        check("valid_d", b(bus.d_valid), b(r.is_d));
                        check("valid_i", b(bus.if_valid), b(!r.is_d));
                        check("rdata", r.is_d ? bus.d_rdata : bus.if_rdata, r.rdata);
                        check("resp_bus_err", b(bus.bus_err), b(r.err));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fetches;
        total = 0;
        bad   = 0;
        ack_lat = 1;
        ack_en  = 1'b1;
        rst = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = 32'd0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_mode  = 1'b0;
        bus.d_addr  = 32'd0;
        bus.d_wdata = 32'd0;

        // Reset state.
        @(negedge clk);
        check("rst_mem_req", b(bus.mem_req), 32'd0);
        check("rst_mem_we", b(bus.mem_we), 32'd0);
        check("rst_mem_mode", b(bus.mem_mode), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_bus_err", b(bus.bus_err), 32'd0);
        check("rst_valids", {30'd0, bus.if_valid, bus.d_valid}, 32'd0);
        check("rst_stall_idle", b(bus.stall_n), 32'd1);
        bus.if_req = 1'b1;
        #1;
        check("rst_stall_req", b(bus.stall_n), 32'd0);
        bus.if_req = 1'b0;
        next_cyc();
        #2 rst = 1'b0;

        // Fetch only: ack in the third busy cycle.
        ack_lat = 3;
        next_cyc();
        push_gnt_i(32'h100);
        push_resp(1'b0, 32'h00A00093, 1'b0);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("f_stall_n", b(bus.stall_n), b(c >= 3));
            check("f_mem_req", b(bus.mem_req), b(c >= 1 && c <= 3));
            check("f_if_valid", b(bus.if_valid), b(c == 3));
            next_cyc();
            if (c == 3) bus.if_req = 1'b0;
        end
        drain("f_drain", 4);

        // Simultaneous fetch and data read: data first, stall held until the fetch completes.
        ack_lat = 1;
        next_cyc();
        push_gnt_d(1'b0, 32'h200, 32'h1111_2222, 1'b0);
        push_resp(1'b1, mem_fn(32'h200), 1'b0);
        push_gnt_i(32'h204);
        push_resp(1'b0, mem_fn(32'h204), 1'b0);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h204;
        bus.d_read  = 1'b1;
        bus.d_addr  = 32'h200;
        bus.d_wdata = 32'h1111_2222;
        bus.d_mode  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("s_stall_n", b(bus.stall_n), b(c >= 3));
            check("s_d_valid", b(bus.d_valid), b(c == 1));
            check("s_if_valid", b(bus.if_valid), b(c == 3));
            next_cyc();
            if (c == 1) bus.d_read = 1'b0;
            if (c == 3) bus.if_req = 1'b0;
        end
        drain("s_drain", 4);

        // Starvation guard: two rounds of four data writes then one fetch.
        next_cyc();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) begin
                push_gnt_d(1'b1, 32'h300, 32'hA5A5_0F0F, 1'b1);
                push_resp(1'b1, mem_fn(32'h300), 1'b0);
            end
            push_gnt_i(32'h400);
            push_resp(1'b0, mem_fn(32'h400), 1'b0);
        end
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h400;
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h300;
        bus.d_wdata = 32'hA5A5_0F0F;
        bus.d_mode  = 1'b1;
        fetches = 0;
        for (int n = 0; n < 60 && fetches < 2; n++) begin
            @(negedge clk);
            if (bus.d_valid) check("b_stall_on_dvalid", b(bus.stall_n), 32'd0);
            if (bus.if_valid) fetches++;
            next_cyc();
        end
        bus.if_req  = 1'b0;
        bus.d_write = 1'b0;
        check("b_fetch_count", 32'(fetches), 32'd2);
        drain("b_drain", 6);

        // Write with mode; fields latched, we cleared after completion, others held.
        ack_lat = 2;
        next_cyc();
        push_gnt_d(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1);
        push_resp(1'b1, mem_fn(32'h40), 1'b0);
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h40;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_mode  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("w_d_valid", b(bus.d_valid), b(c == 2));
            check("w_mem_we", b(bus.mem_we), b(c == 1 || c == 2));
            if (c == 3) begin
                check("w_hold_addr", bus.mem_addr, 32'h40);
                check("w_hold_mode", b(bus.mem_mode), 32'd1);
                check("w_hold_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            end
            next_cyc();
            if (c == 2) bus.d_write = 1'b0;
        end
        drain("w_drain", 4);

        // Read and write together is a write.
        ack_lat = 1;
        next_cyc();
        push_gnt_d(1'b1, 32'h44, 32'h0123_4567, 1'b0);
        push_resp(1'b1, mem_fn(32'h44), 1'b0);
        bus.d_read  = 1'b1;
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h44;
        bus.d_wdata = 32'h0123_4567;
        bus.d_mode  = 1'b0;
        next_cyc();
        @(negedge clk);
        check("rw_d_valid", b(bus.d_valid), 32'd1);
        next_cyc();
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        drain("rw_drain", 4);

        // Timeout: no ack ever; abort in the cycle after TO busy cycles.
        ack_en = 1'b0;
        next_cyc();
        push_gnt_d(1'b0, 32'h80, 32'd0, 1'b0);
        push_resp(1'b1, 32'd0, 1'b1);
        bus.d_read  = 1'b1;
        bus.d_addr  = 32'h80;
        bus.d_wdata = 32'd0;
        for (int c = 0; c < TO + 3; c++) begin
            @(negedge clk);
            check("t_bus_err", b(bus.bus_err), b(c == TO + 1));
            check("t_d_valid", b(bus.d_valid), b(c == TO + 1));
            check("t_mem_req", b(bus.mem_req), b(c >= 1 && c <= TO + 1));
            if (c == TO + 1) check("t_d_rdata", bus.d_rdata, 32'd0);
            next_cyc();
            if (c == TO + 1) bus.d_read = 1'b0;
        end
        drain("t_drain", 4);

        // Ack arriving in the timeout cycle completes normally.
        ack_en  = 1'b1;
        ack_lat = TO + 1;
        next_cyc();
        push_gnt_d(1'b0, 32'h84, 32'd0, 1'b0);
        push_resp(1'b1, mem_fn(32'h84), 1'b0);
        bus.d_read = 1'b1;
        bus.d_addr = 32'h84;
        for (int c = 0; c < TO + 3; c++) begin
            @(negedge clk);
            check("c_bus_err", b(bus.bus_err), 32'd0);
            check("c_d_valid", b(bus.d_valid), b(c == TO + 1));
            next_cyc();
            if (c == TO + 1) bus.d_read = 1'b0;
        end
        drain("c_drain", 4);

        // Async reset in the middle of a fetch, then re-grant of the held request.
        ack_lat = 3;
        next_cyc();
        push_gnt_i(32'h500);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h500;
        @(negedge clk);
        next_cyc();
        @(negedge clk);
        check("r_mem_req_before", b(bus.mem_req), 32'd1);
        next_cyc();
        #2 rst = 1'b1;
        #1;
        check("r_mem_req_now", b(bus.mem_req), 32'd0);
        check("r_if_valid_now", b(bus.if_valid), 32'd0);
        check("r_stall_n_now", b(bus.stall_n), 32'd0);
        @(negedge clk);
        check("r_if_valid", b(bus.if_valid), 32'd0);
        next_cyc();
        push_gnt_i(32'h500);
        push_resp(1'b0, mem_fn(32'h500), 1'b0);
        #2 rst = 1'b0;
        fetches = 0;
        for (int n = 0; n < 10 && fetches == 0; n++) begin
            @(negedge clk);
            if (bus.if_valid) fetches++;
            next_cyc();
        end
        bus.if_req = 1'b0;
        check("r_regrant", 32'(fetches), 32'd1);
        drain("r_drain", 4);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
